// File: rtl/gpu_pkg.sv
// Shared GPU types and constants: colour/coordinate/pixel widths, sprite edge
// length (also used by the sprite RAM) and the default background/key colours.
package gpu_pkg;

  localparam int GPU_DATA_WIDTH   = 32;
  localparam int GPU_COLOR_WIDTH  = 12;
  localparam int GPU_PIXEL_WIDTH  = 10;
  localparam int GPU_TEXTURE_SIDE = 16;

  typedef logic [GPU_COLOR_WIDTH-1:0] color_t;
  typedef logic [GPU_DATA_WIDTH-1:0]  coord_t;
  typedef logic [GPU_PIXEL_WIDTH-1:0] pixel_t;

  localparam color_t GPU_BG_COLOR          = 12'h000;
  localparam color_t GPU_TRANSPARENT_COLOR = 12'hF0F;

endpackage

// File: rtl/gpu_sprite_hit.sv
// Combinational coverage test of one screen pixel against one sprite, with the
// texel offset inside the sprite. Sums are one bit wider than a coordinate so a
// sprite near the top of the coordinate range never wraps onto the screen.
module gpu_sprite_hit #(
  parameter int DATA_WIDTH   = 32,
  parameter int PIXEL_WIDTH  = 10,
  parameter int TEXTURE_SIDE = 16,
  parameter int TEX_BITS     = $clog2(TEXTURE_SIDE)
) (
  input  logic [PIXEL_WIDTH-1:0] px,
  input  logic [PIXEL_WIDTH-1:0] py,
  input  logic [DATA_WIDTH-1:0]  sx,
  input  logic [DATA_WIDTH-1:0]  sy,
  output logic                   hit,
  output logic [TEX_BITS-1:0]    dx,
  output logic [TEX_BITS-1:0]    dy
);

  localparam logic [DATA_WIDTH:0] SIDE = (DATA_WIDTH+1)'(TEXTURE_SIDE);

  logic [DATA_WIDTH:0] px_e, py_e, sx_e, sy_e, sx_end, sy_end;

  always_comb begin
    px_e   = {{(DATA_WIDTH+1-PIXEL_WIDTH){1'b0}}, px};
    py_e   = {{(DATA_WIDTH+1-PIXEL_WIDTH){1'b0}}, py};
    sx_e   = {1'b0, sx};
    sy_e   = {1'b0, sy};
    sx_end = sx_e + SIDE;
    sy_end = sy_e + SIDE;
    hit    = (px_e >= sx_e) && (px_e < sx_end) && (py_e >= sy_e) && (py_e < sy_end);
    // Only the low bits matter: the offset is below TEXTURE_SIDE whenever hit=1.
    dx     = px[TEX_BITS-1:0] - sx[TEX_BITS-1:0];
    dy     = py[TEX_BITS-1:0] - sy[TEX_BITS-1:0];
  end

endmodule

// File: rtl/gpu_cluster_shader.sv
// Per-cluster pixel shader: per-sprite hit test, texel fetch from the sprite RAM
// and colour merge, fixed 2-edge latency. Build option GPU_SHADER_TRANSPARENCY_EN
// turns texels equal to TRANSPARENT_COLOR into background misses.
module gpu_cluster_shader
  import gpu_pkg::*;
#(
  parameter int                     DATA_WIDTH        = GPU_DATA_WIDTH,
  parameter int                     COLOR_WIDTH       = GPU_COLOR_WIDTH,
  parameter int                     CLUSTER_SIZE      = 10,
  parameter int                     TEXTURE_SIDE      = GPU_TEXTURE_SIDE,
  parameter int                     TEXTURE_WIDTH     = $clog2(TEXTURE_SIDE*TEXTURE_SIDE),
  parameter int                     PIXEL_WIDTH       = GPU_PIXEL_WIDTH,
  parameter logic [COLOR_WIDTH-1:0] BG_COLOR          = GPU_BG_COLOR,
  parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = GPU_TRANSPARENT_COLOR
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          frame_start,
  input  logic                                          pix_valid,
  input  logic [PIXEL_WIDTH-1:0]                        pix_x,
  input  logic [PIXEL_WIDTH-1:0]                        pix_y,
  input  logic [CLUSTER_SIZE-1:0][1:0][DATA_WIDTH-1:0]  rcoord,
  output logic [TEXTURE_WIDTH-1:0]                      rindex,
  input  logic [COLOR_WIDTH-1:0]                        rcolor,
  output logic                                          out_valid,
  output logic                                          out_hit,
  output logic [COLOR_WIDTH-1:0]                        out_color
);

  localparam int TEX_BITS = $clog2(TEXTURE_SIDE);

`ifdef GPU_SHADER_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  // Handshake: pix_valid qualifies pix_x/pix_y for one cycle and is never
  // stalled; out_valid pulses exactly 2 edges later, in order, with no ready.

  logic [CLUSTER_SIZE-1:0][1:0][DATA_WIDTH-1:0] shadow;
  logic [CLUSTER_SIZE-1:0]                      hit_vec;
  logic [CLUSTER_SIZE-1:0][TEX_BITS-1:0]        dx_vec;
  logic [CLUSTER_SIZE-1:0][TEX_BITS-1:0]        dy_vec;
  logic                                         any_hit;
  logic [TEXTURE_WIDTH-1:0]                     sel_index;
  logic                                         s1_valid, s1_hit;
  logic                                         s2_valid, s2_hit;
  logic                                         key_drop;

  // Shadow copy isolates the frame being drawn from mid-frame RAM writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '1;
    end else if (frame_start) begin
      shadow <= rcoord;
    end
  end

  for (genvar gi = 0; gi < CLUSTER_SIZE; gi++) begin : g_sprite
    gpu_sprite_hit #(
      .DATA_WIDTH   (DATA_WIDTH),
      .PIXEL_WIDTH  (PIXEL_WIDTH),
      .TEXTURE_SIDE (TEXTURE_SIDE),
      .TEX_BITS     (TEX_BITS)
    ) u_hit (
      .px  (pix_x),
      .py  (pix_y),
      .sx  (shadow[gi][0]),
      .sy  (shadow[gi][1]),
      .hit (hit_vec[gi]),
      .dx  (dx_vec[gi]),
      .dy  (dy_vec[gi])
    );
  end

  // Scan from the top so the lowest-numbered hitting sprite is written last.
  always_comb begin
    any_hit   = 1'b0;
    sel_index = '0;
    for (int j = CLUSTER_SIZE-1; j >= 0; j--) begin
      if (hit_vec[j]) begin
        any_hit   = 1'b1;
        sel_index = {dy_vec[j], dx_vec[j]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      rindex   <= '0;
    end else if (pix_valid) begin
      s1_valid <= 1'b1;
      s1_hit   <= any_hit;
      rindex   <= sel_index;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // The RAM registers rcolor during this stage; only the flags travel here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_hit   <= s1_hit;
    end
  end

  assign key_drop = TRANSP_EN && (rcolor == TRANSPARENT_COLOR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_color <= BG_COLOR;
    end else if (s2_valid) begin
      out_valid <= 1'b1;
      out_hit   <= s2_hit && !key_drop;
      out_color <= (s2_hit && !key_drop) ? rcolor : BG_COLOR;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpu_cluster_shader.sv
// Directed bench for gpu_cluster_shader with a registered sprite RAM model.
module tb_gpu_cluster_shader;
  import gpu_pkg::*;

  localparam int CS = 10;

  logic                      clk;
  logic                      rst;
  logic                      frame_start;
  logic                      pix_valid;
  logic [9:0]                pix_x, pix_y;
  logic [CS-1:0][1:0][31:0]  rcoord;
  logic [7:0]                rindex;
  logic [11:0]               rcolor;
  logic                      out_valid, out_hit;
  logic [11:0]               out_color;
  logic [11:0]               tex [256];

  int total = 0;
  int bad   = 0;

  gpu_cluster_shader dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .rcoord      (rcoord),
    .rindex      (rindex),
    .rcolor      (rcolor),
    .out_valid   (out_valid),
    .out_hit     (out_hit),
    .out_color   (out_color)
  );

  // Clock and RAM model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rcolor <= tex[rindex];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  // One isolated pixel: check rindex after the sampling edge, nothing at t+1,
  // then the merged result at t+2.
  task automatic pixel(input string tag, input int x, input int y, input bit fs,
                       input logic [7:0] idx, input bit hit, input logic [11:0] col);
    @(negedge clk);
    pix_valid   = 1'b1;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    frame_start = fs;
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    chk({tag, "_rindex"}, 32'(rindex), 32'(idx));
    @(posedge clk);
    #1;
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_hit"}, 32'(out_hit), 32'(hit));
    chk({tag, "_color"}, 32'(out_color), 32'(col));
  endtask

  initial begin
    logic [9:0]  bx [4];
    logic [9:0]  by [4];
    logic        eh [4];
    logic [11:0] ec [4];

    for (int i = 0; i < 256; i++) tex[i] = 12'h123;
    tex[8'h23] = 12'hABC;
    tex[8'hFF] = 12'h5A5;
    tex[8'h11] = 12'h7E1;
    tex[8'h13] = 12'h0C3;
    tex[8'h44] = 12'hF0F;
    tex[8'h01] = 12'h201;
    tex[8'h10] = 12'h310;
    tex[8'h05] = 12'h405;

    rst         = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    rcoord      = '1;
    #12;
    chk("reset_rindex", 32'(rindex), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_hit", 32'(out_hit), 32'd0);
    chk("reset_color", 32'(out_color), 32'h000);
    @(negedge clk);
    rst = 1'b1;

    // Shadow still all-ones: nothing can hit.
    pixel("nosprite", 5, 5, 1'b0, 8'h00, 1'b0, 12'h000);

    rcoord[0][0] = 32'd100;
    rcoord[0][1] = 32'd50;
    frame();
    pixel("basic", 103, 52, 1'b0, 8'h23, 1'b1, 12'hABC);
    pixel("edge_in", 115, 65, 1'b0, 8'hFF, 1'b1, 12'h5A5);
    pixel("edge_out", 116, 65, 1'b0, 8'h00, 1'b0, 12'h000);
    pixel("below_sx", 99, 50, 1'b0, 8'h00, 1'b0, 12'h000);

    rcoord = '1;
    rcoord[2] = {32'd0, 32'd0};
    rcoord[7] = {32'd0, 32'd0};
    frame();
    pixel("overlap_same", 1, 1, 1'b0, 8'h11, 1'b1, 12'h7E1);

    // Sprite 7 alone would give index 22; sprite 2 must win with 11.
    rcoord[2] = {32'd1, 32'd1};
    frame();
    pixel("overlap_prio", 2, 2, 1'b0, 8'h11, 1'b1, 12'h7E1);

    rcoord = '1;
    rcoord[0] = {32'd200, 32'd200};
    pixel("no_tearing", 2, 2, 1'b0, 8'h11, 1'b1, 12'h7E1);
    frame();
    pixel("new_frame_old", 2, 2, 1'b0, 8'h00, 1'b0, 12'h000);
    pixel("new_frame_new", 203, 201, 1'b0, 8'h13, 1'b1, 12'h0C3);

`ifdef GPU_SHADER_TRANSPARENCY_EN
    pixel("transparent", 204, 204, 1'b0, 8'h44, 1'b0, 12'h000);
`else
    pixel("transparent", 204, 204, 1'b0, 8'h44, 1'b1, 12'hF0F);
`endif

    // Pixel on the frame_start edge still sees the old shadow.
    rcoord[0] = {32'd300, 32'd300};
    pixel("same_edge", 200, 200, 1'b1, 8'h00, 1'b1, 12'h123);
    pixel("after_same_edge", 305, 300, 1'b0, 8'h05, 1'b1, 12'h405);

    // Back-to-back burst, outputs checked in order 2 edges later.
    bx[0] = 10'd300; by[0] = 10'd300; eh[0] = 1'b1; ec[0] = 12'h123;
    bx[1] = 10'd301; by[1] = 10'd300; eh[1] = 1'b1; ec[1] = 12'h201;
    bx[2] = 10'd300; by[2] = 10'd301; eh[2] = 1'b1; ec[2] = 12'h310;
    bx[3] = 10'd0;   by[3] = 10'd0;   eh[3] = 1'b0; ec[3] = 12'h000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        pix_valid = 1'b1;
        pix_x     = bx[i];
        pix_y     = by[i];
      end else begin
        pix_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 2) begin
        chk($sformatf("burst%0d_valid", i-2), 32'(out_valid), 32'd1);
        chk($sformatf("burst%0d_hit", i-2), 32'(out_hit), 32'(eh[i-2]));
        chk($sformatf("burst%0d_color", i-2), 32'(out_color), 32'(ec[i-2]));
      end
    end
    @(posedge clk);
    #1;
    chk("burst_end_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a 4-pixel burst.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_x     = 10'(300 + i);
      pix_y     = 10'd300;
      @(posedge clk);
    end
    #1;
    chk("preburst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    pix_x = 10'd303;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_hit", 32'(out_hit), 32'd0);
    chk("rst_color", 32'(out_color), 32'h000);
    chk("rst_rindex", 32'(rindex), 32'd0);
    @(negedge clk);
    pix_valid = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_valid", i), 32'(out_valid), 32'd0);
    end
    // Reset also parks every sprite off-screen.
    pixel("post_rst_shadow", 300, 300, 1'b0, 8'h00, 1'b0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
